// File: rtl/puf_race_ctrl_if.sv
// puf_race_ctrl_if: bus-side challenge/response handshake; PUF_STABILITY_EN adds stability outputs
interface puf_race_ctrl_if #(
  parameter int CHAL_W = 64
`ifdef PUF_STABILITY_EN
  , parameter int OW = 3
`endif
);
  logic [CHAL_W-1:0] chal_in;
  logic chal_valid, chal_ready, resp_out, resp_valid, resp_ready;
`ifdef PUF_STABILITY_EN
  logic resp_unstable;
  logic [OW-1:0] ones_count;
  modport master(output chal_in, chal_valid, resp_ready, input chal_ready, resp_out, resp_valid, resp_unstable, ones_count);
  modport slave(input chal_in, chal_valid, resp_ready, output chal_ready, resp_out, resp_valid, resp_unstable, ones_count);
`else
  modport master(output chal_in, chal_valid, resp_ready, input chal_ready, resp_out, resp_valid);
  modport slave(input chal_in, chal_valid, resp_ready, output chal_ready, resp_out, resp_valid);
`endif
endinterface

// File: rtl/puf_race_ctrl.sv
// puf_race_ctrl: arbiter-PUF race sequencer with majority vote; PUF_STABILITY_EN adds resp_unstable/ones_count
module puf_race_ctrl #(
  parameter int CHAL_W = 64,
  parameter int SETTLE_CYC = 8,
  parameter int NUM_TRIALS = 7
) (
  input  logic              clk,
  input  logic              rst,
  puf_race_ctrl_if.slave    bus,
  output logic [CHAL_W-1:0] o_chain_chal,
  output logic              o_chain_launch,
  output logic              o_arb_clr,
  input  logic              i_arb_resp,
  output logic              o_busy
);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TW = $clog2(NUM_TRIALS + 1);
  localparam int OW = $clog2(NUM_TRIALS + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, RACE, SAMPLE, DONE} state_t;
  state_t            r_state;
  logic [CHAL_W-1:0] r_chal;
  logic [CW-1:0]     r_cnt;
  logic [TW-1:0]     r_trial;
  logic [OW-1:0]     r_ones;
  logic [1:0]        r_sync;
  logic              r_chal_ready, r_launch, r_clr, r_resp_out, r_resp_valid, r_busy;
  logic              w_phase_end, w_last;
  assign w_phase_end = r_cnt == CW'(SETTLE_CYC - 1);
  assign w_last      = r_trial == TW'(NUM_TRIALS - 1);
`ifdef PUF_STABILITY_EN
  logic          r_unstable;
  logic [OW-1:0] r_ones_count;
  // stability summary, latched together with the voted response
  always_ff @(posedge clk)
    if (rst) begin
      r_unstable   <= 1'b0;
      r_ones_count <= '0;
    end else if (r_state == DONE && !r_resp_valid) begin
      r_unstable   <= (r_ones != '0) && (r_ones != OW'(NUM_TRIALS));
      r_ones_count <= r_ones;
    end
  assign bus.resp_unstable = r_unstable;
  assign bus.ones_count    = r_ones_count;
`endif
  // two-flop synchronizer for the asynchronous arbiter latch
  always_ff @(posedge clk)
    r_sync <= rst ? 2'b00 : {r_sync[0], i_arb_resp};
  // race sequencer: clear, race, sample per trial, then vote and hold the response
  always_ff @(posedge clk)
    if (rst) begin
      r_state      <= IDLE;
      r_chal       <= '0;
      r_cnt        <= '0;
      r_trial      <= '0;
      r_ones       <= '0;
      r_chal_ready <= 1'b1;
      r_launch     <= 1'b0;
      r_clr        <= 1'b1;
      r_resp_out   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.chal_valid) begin
          r_chal       <= bus.chal_in;
          r_trial      <= '0;
          r_ones       <= '0;
          r_cnt        <= '0;
          r_chal_ready <= 1'b0;
          r_busy       <= 1'b1;
          r_state      <= CLEAR;
        end
        CLEAR: if (w_phase_end) begin
          r_cnt    <= '0;
          r_launch <= 1'b1;
          r_clr    <= 1'b0;
          r_state  <= RACE;
        end else r_cnt <= r_cnt + 1'b1;
        RACE: if (w_phase_end) begin
          r_cnt   <= '0;
          r_state <= SAMPLE;
        end else r_cnt <= r_cnt + 1'b1;
        SAMPLE: begin
          r_ones   <= r_ones + OW'(r_sync[1]);
          r_launch <= 1'b0;
          r_clr    <= 1'b1;
          r_trial  <= w_last ? r_trial : r_trial + 1'b1;
          r_state  <= w_last ? DONE : CLEAR;
        end
        DONE: if (!r_resp_valid) begin
          r_resp_valid <= 1'b1;
          r_resp_out   <= r_ones > OW'(NUM_TRIALS / 2);
        end else if (bus.resp_ready) begin
          r_resp_valid <= 1'b0;
          r_chal_ready <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.chal_ready = r_chal_ready;
  assign bus.resp_out   = r_resp_out;
  assign bus.resp_valid = r_resp_valid;
  assign o_chain_chal   = r_chal;
  assign o_chain_launch = r_launch;
  assign o_arb_clr      = r_clr;
  assign o_busy         = r_busy;
endmodule

// File: tb/tb_puf_race_ctrl.sv
// tb_puf_race_ctrl: directed vectors for puf_race_ctrl (SETTLE_CYC=4, NUM_TRIALS=5), honours PUF_STABILITY_EN
module tb_puf_race_ctrl;
  logic clk = 0, rst = 1, arb_resp = 0;
  logic [63:0] chain_chal;
  logic launch, clr, busy;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic [63:0] chal;
    logic [4:0]  pat;
    logic        exp_out;
    int          exp_ones;
    int          hold;
    logic        early;
  } vec_t;
  vec_t vecs[5];
`ifdef PUF_STABILITY_EN
  puf_race_ctrl_if #(.CHAL_W(64), .OW(3)) bus();
`else
  puf_race_ctrl_if #(.CHAL_W(64)) bus();
`endif
  puf_race_ctrl #(.CHAL_W(64), .SETTLE_CYC(4), .NUM_TRIALS(5)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_chain_chal(chain_chal),
    .o_chain_launch(launch), .o_arb_clr(clr), .i_arb_resp(arb_resp), .o_busy(busy));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v);
    int cyc = 0, rises = 0, hi = 0, clr_run = 0, pulse_bad = 0, clr_bad = 0;
    logic prev = 0;
    logic held;
    chk("ready_before_accept", 64'(bus.chal_ready), 64'd1);
    bus.resp_ready = v.early;
    bus.chal_in = v.chal;
    bus.chal_valid = 1;
    arb_resp = v.pat[0];
    @(posedge clk);
    while (cyc < 200) begin
      @(negedge clk);
      bus.chal_valid = 0;
      if (launch && !prev) begin
        if (rises > 0 ? clr_run != 4 : clr_run < 4) clr_bad++;
        rises++;
      end
      if (!launch && prev) begin
        if (hi != 5) pulse_bad++;
        hi = 0;
      end
      if (launch) begin
        hi++;
        clr_run = 0;
        if (clr) clr_bad++;
      end else begin
        if (clr) clr_run++;
        else clr_bad++;
        if (rises < 5) arb_resp = v.pat[rises];
      end
      prev = launch;
      if (bus.resp_valid) break;
      @(posedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'd46);
    chk("chain_chal", chain_chal, v.chal);
    chk("launch_pulses", 64'(rises), 64'd5);
    chk("pulse_len_errs", 64'(pulse_bad), 64'd0);
    chk("arb_clr_errs", 64'(clr_bad), 64'd0);
    chk("resp_out", 64'(bus.resp_out), 64'(v.exp_out));
    chk("busy_done", 64'(busy), 64'd1);
`ifdef PUF_STABILITY_EN
    chk("ones_count", 64'(bus.ones_count), 64'(v.exp_ones));
    chk("resp_unstable", 64'(bus.resp_unstable), 64'(v.exp_ones != 0 && v.exp_ones != 5));
`endif
    held = bus.resp_out;
    for (int h = 0; h < v.hold; h++) begin
      bus.chal_in = ~v.chal;
      bus.chal_valid = 1;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("hold_out", 64'(bus.resp_out), 64'(held));
      chk("hold_chal_ready", 64'(bus.chal_ready), 64'd0);
      chk("hold_chain_chal", chain_chal, v.chal);
    end
    bus.chal_valid = 0;
    bus.resp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 0;
    chk("post_valid", 64'(bus.resp_valid), 64'd0);
    chk("post_chal_ready", 64'(bus.chal_ready), 64'd1);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_chain_chal", chain_chal, v.chal);
  endtask
  initial begin
    vecs[0] = '{64'hA5A5A5A5A5A5A5A5, 5'b11111, 1'b1, 5, 0, 1'b0};
    vecs[1] = '{64'h0123456789ABCDEF, 5'b00101, 1'b0, 2, 0, 1'b0};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 5'b00000, 1'b0, 0, 10, 1'b0};
    vecs[3] = '{64'h0000000000000000, 5'b10110, 1'b1, 3, 0, 1'b1};
    vecs[4] = '{64'hDEADBEEFCAFEF00D, 5'b01000, 1'b0, 1, 3, 1'b0};
    bus.chal_in = '0;
    bus.chal_valid = 0;
    bus.resp_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_chal_ready", 64'(bus.chal_ready), 64'd1);
    chk("rst_arb_clr", 64'(clr), 64'd1);
    chk("rst_launch", 64'(launch), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_chain_chal", chain_chal, 64'd0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    bus.chal_in = 64'h1122334455667788;
    bus.chal_valid = 1;
    begin
      int rises = 0, guard = 0;
      logic prev = 0;
      @(posedge clk);
      @(negedge clk);
      bus.chal_valid = 0;
      while (rises < 3 && guard < 100) begin
        if (launch && !prev) rises++;
        prev = launch;
        if (rises < 3) begin
          @(posedge clk);
          @(negedge clk);
        end
        guard++;
      end
      chk("midrst_reached_race3", 64'(rises), 64'd3);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("midrst_launch", 64'(launch), 64'd0);
    chk("midrst_clr", 64'(clr), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("midrst_chal_ready", 64'(bus.chal_ready), 64'd1);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("midrst_no_resp", 64'(bus.resp_valid), 64'd0);
    end
    run_vec(vecs[0]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/puf_race_ctrl.md
Name: puf_race_ctrl

Overview:
- Drives the far end of the arbiter-PUF mux delay chain.
- Accepts a challenge and applies it to the chain's 2:1 mux select lines, then launches a rising edge into both chain inputs.
- Samples the arbiter latch after the race settles, repeats the race NUM_TRIALS times and majority-votes to one response bit.
- Sits between the bus-side register interface and the mux chain / arbiter latch.

Parameters:
- CHAL_W, 64: challenge width; one bit per mux stage pair.
- SETTLE_CYC, 8: cycles for each clear phase and each race phase; must be >= 3 to cover the internal synchronizer.
- NUM_TRIALS, 7: races per challenge; must be >= 1 and odd. If even, a tie resolves to 0.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- chal_in, in, CHAL_W: challenge from the bus side.
- chal_valid, in, 1: challenge valid.
- chal_ready, out, 1: controller can accept a challenge.
- chain_chal, out, CHAL_W: registered challenge driving the mux select lines.
- chain_launch, out, 1: race edge, fanned to both chain inputs.
- arb_clr, out, 1: clears the arbiter latch.
- arb_resp, in, 1: arbiter latch output; asynchronous to clk.
- resp_out, out, 1: majority-voted response.
- resp_valid, out, 1: response valid.
- resp_ready, in, 1: consumer accepts the response.
- busy, out, 1: high in any state except IDLE.

Behaviour:
- Reset values:
  - state = IDLE; chal_ready = 1; chain_chal = 0; chain_launch = 0; arb_clr = 1.
  - resp_out = 0; resp_valid = 0; busy = 0.
  - trial counter = 0; ones counter = 0; both synchronizer flops = 0.
- Reset asserted mid-operation aborts the race and returns all of the above to reset values on the next edge. The partial result is discarded.
- Synchronizer: arb_resp passes through 2 flops; arb_sync is the second flop. Only arb_sync is used internally.
- Ones counter width: clog2(NUM_TRIALS+1).
- States:
  - IDLE:
    - chal_ready = 1, arb_clr = 1, chain_launch = 0.
    - On chal_valid: capture chal_in into chain_chal, clear both counters, go to CLEAR.
  - CLEAR:
    - SETTLE_CYC cycles; chain_launch = 0, arb_clr = 1. This discharges the chain and resets the latch.
    - Then go to RACE.
  - RACE:
    - SETTLE_CYC cycles; chain_launch = 1, arb_clr = 0.
    - Then go to SAMPLE.
  - SAMPLE:
    - 1 cycle; chain_launch = 1, arb_clr = 0; ones += arb_sync.
    - If trial == NUM_TRIALS-1, go to DONE; otherwise trial++ and go to CLEAR.
  - DONE:
    - resp_valid = 1; resp_out = (ones_final > NUM_TRIALS/2), using integer division and strict greater-than.
    - chain_launch = 0, arb_clr = 1.
    - Hold until resp_ready; on resp_valid & resp_ready go to IDLE.
- Timing and handshake:
  - Per-trial length is 2*SETTLE_CYC+1 cycles.
  - resp_valid rises exactly NUM_TRIALS*(2*SETTLE_CYC+1)+1 cycles after the chal_valid & chal_ready edge. Default: 7*17+1 = 120.
  - chal_ready is 0 outside IDLE; chal_valid is ignored there. chain_chal is stable from capture until the next capture.
  - resp_out is stable while resp_valid = 1.
  - resp_ready while resp_valid = 0 is ignored.
  - Handshake in DONE: chal_ready rises the following cycle. There is no same-cycle turnaround.
- NUM_TRIALS = 1 is legal: a single race, and the response equals that sample.

Optional Feature:
- Macro: PUF_STABILITY_EN
- Defined: adds two outputs, both valid with resp_valid and reset to 0:
  - resp_unstable (out, 1): 1 when ones_final != 0 and ones_final != NUM_TRIALS.
  - ones_count (out, clog2(NUM_TRIALS+1)): ones_final.
- Undefined: neither port exists and no extra logic is generated. Core behaviour is identical.

Test Plan:
- Reset and idle: SETTLE_CYC=4, NUM_TRIALS=5; assert rst 2 cycles -> chal_ready=1, arb_clr=1, chain_launch=0, resp_valid=0, busy=0.
- All-ones race: chal 0xA5A5A5A5A5A5A5A5 accepted, arb_resp held 1 -> chain_chal equals the challenge; chain_launch pulses 5 times, each 5 cycles high; resp_valid at cycle 46 after accept; resp_out=1. With PUF_STABILITY_EN: ones_count=5, resp_unstable=0.
- Noisy race: arb_resp = 1,0,1,0,0 across the 5 trials -> resp_out=0. With PUF_STABILITY_EN: ones_count=2, resp_unstable=1.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_valid and resp_out held, chal_ready=0, and a new chal_valid is ignored. Then resp_ready=1 -> IDLE next cycle; chal_ready=1 one cycle after the handshake.
- Reset mid-race: assert rst during the 3rd RACE phase -> next edge: chain_launch=0, arb_clr=1, busy=0, no resp_valid. A fresh challenge then gives full 46-cycle latency.
- Arbiter clear timing: observe arb_clr=1 for exactly 4 cycles before every chain_launch rise, and arb_clr=0 throughout each RACE and SAMPLE phase.
